// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store front-end for a word-wide data RAM. Accepts
//               byte/halfword/word requests on a valid/ready handshake,
//               turns byte addresses into RAM word addresses, performs
//               sub-word stores as read-modify-write, extracts and
//               sign/zero-extends sub-word loads, and returns a one-cycle
//               response pulse carrying load data or a misalignment error.
//
// Ports       : Clock, Reset (async, active-low)
//               Req_Valid/Req_Ready handshake; Req_Write, Req_Size,
//               Req_Signed, Req_Addr (byte address), Req_Wdata
//               Resp_Valid, Resp_Rdata, Resp_Error
//               Ram_Address, Ram_Write_Data, Ram_Mem_Write, Ram_Read_Data
//               (RAM read data is registered: valid one cycle after the
//               address is presented)
//
// Options     : MAU_PERF_CNT_EN - when defined, adds Load_Count and
//               Store_Count outputs counting non-error load/store responses.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic                  Req_Write,
    input  logic [1:0]            Req_Size,
    input  logic                  Req_Signed,
    input  logic [ADDR_WIDTH+1:0] Req_Addr,
    input  logic [DATA_WIDTH-1:0] Req_Wdata,
    output logic                  Resp_Valid,
    output logic [DATA_WIDTH-1:0] Resp_Rdata,
    output logic                  Resp_Error,
    output logic [ADDR_WIDTH-1:0] Ram_Address,
    output logic [DATA_WIDTH-1:0] Ram_Write_Data,
    output logic                  Ram_Mem_Write,
    input  logic [DATA_WIDTH-1:0] Ram_Read_Data
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [31:0]           Load_Count,
    output logic [31:0]           Store_Count
`endif
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_MERGE  = 2'd3;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    // ------------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merged;

    logic                  r_resp_valid;
    logic                  r_resp_error;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic                  w_accept;
    logic                  w_req_error;
    logic                  w_word_store;
    logic [7:0]            w_lane_byte;
    logic [15:0]           w_lane_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge_data;

    assign w_accept     = Req_Valid && Req_Ready;
    assign w_word_store = r_write && (r_size == c_SIZE_WORD);

    // Alignment / size legality of the incoming request
    always_comb begin
        w_req_error = 1'b0;
        case (Req_Size)
            c_SIZE_BYTE: w_req_error = 1'b0;
            c_SIZE_HALF: w_req_error = Req_Addr[0];
            c_SIZE_WORD: w_req_error = |Req_Addr[1:0];
            default:     w_req_error = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // Illegal requests are answered without leaving IDLE
                if (w_accept && !w_req_error) begin
                    w_next_state = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (w_word_store) begin
                    w_next_state = c_ST_IDLE;
                end else begin
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                // Only sub-word stores reach WAIT with r_write set
                if (r_write) begin
                    w_next_state = c_ST_MERGE;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_MERGE: w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        Req_Ready      = 1'b0;
        Ram_Address    = r_addr[ADDR_WIDTH+1:2];
        Ram_Mem_Write  = 1'b0;
        Ram_Write_Data = '0;
        case (r_state)
            c_ST_IDLE: begin
                Req_Ready   = 1'b1;
                // Present the incoming word address so the RAM can start early
                Ram_Address = Req_Addr[ADDR_WIDTH+1:2];
            end
            c_ST_ACCESS: begin
                if (w_word_store) begin
                    Ram_Mem_Write  = 1'b1;
                    Ram_Write_Data = r_wdata;
                end
            end
            c_ST_MERGE: begin
                Ram_Mem_Write  = 1'b1;
                Ram_Write_Data = r_merged;
            end
            default: begin
                Req_Ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Lane extraction and merge (little-endian lanes)
    // ------------------------------------------------------------------------
    assign w_lane_byte = Ram_Read_Data[{r_addr[1:0], 3'b000} +: 8];
    assign w_lane_half = Ram_Read_Data[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = Ram_Read_Data;
        case (r_size)
            c_SIZE_BYTE: w_load_data = {{(DATA_WIDTH-8){r_signed & w_lane_byte[7]}}, w_lane_byte};
            c_SIZE_HALF: w_load_data = {{(DATA_WIDTH-16){r_signed & w_lane_half[15]}}, w_lane_half};
            default:     w_load_data = Ram_Read_Data;
        endcase
    end

    always_comb begin
        w_merge_data = Ram_Read_Data;
        if (r_size == c_SIZE_BYTE) begin
            w_merge_data[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_size == c_SIZE_HALF) begin
            w_merge_data[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // Request latch, merge register and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;

            if (w_accept) begin
                r_write  <= Req_Write;
                r_size   <= Req_Size;
                r_signed <= Req_Signed;
                r_addr   <= Req_Addr;
                r_wdata  <= Req_Wdata;
                if (w_req_error) begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b1;
                    r_resp_rdata <= '0;
                end
            end

            case (r_state)
                c_ST_ACCESS: begin
                    if (w_word_store) begin
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_rdata <= '0;
                    end
                end
                c_ST_WAIT: begin
                    if (r_write) begin
                        r_merged <= w_merge_data;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_rdata <= w_load_data;
                    end
                end
                c_ST_MERGE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_merged <= r_merged;
                end
            endcase
        end
    end

    assign Resp_Valid = r_resp_valid;
    assign Resp_Error = r_resp_error;
    assign Resp_Rdata = r_resp_rdata;

`ifdef MAU_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters: successful responses only, free-running wrap
    // ------------------------------------------------------------------------
    logic        w_load_resp;
    logic        w_store_resp;
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    assign w_load_resp  = (r_state == c_ST_WAIT) && !r_write;
    assign w_store_resp = ((r_state == c_ST_ACCESS) && w_word_store) ||
                          (r_state == c_ST_MERGE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_load_count  <= '0;
            r_store_count <= '0;
        end else begin
            if (w_load_resp) begin
                r_load_count <= r_load_count + 32'd1;
            end
            if (w_store_resp) begin
                r_store_count <= r_store_count + 32'd1;
            end
        end
    end

    assign Load_Count  = r_load_count;
    assign Store_Count = r_store_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               registered-read RAM model attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        Clock;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Signed;
    logic [17:0] Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Resp_Valid;
    logic [31:0] Resp_Rdata;
    logic        Resp_Error;
    logic [15:0] Ram_Address;
    logic [31:0] Ram_Write_Data;
    logic        Ram_Mem_Write;
    logic [31:0] Ram_Read_Data;
`ifdef MAU_PERF_CNT_EN
    logic [31:0] Load_Count;
    logic [31:0] Store_Count;
`endif

    mem_access_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Write      (Req_Write),
        .Req_Size       (Req_Size),
        .Req_Signed     (Req_Signed),
        .Req_Addr       (Req_Addr),
        .Req_Wdata      (Req_Wdata),
        .Resp_Valid     (Resp_Valid),
        .Resp_Rdata     (Resp_Rdata),
        .Resp_Error     (Resp_Error),
        .Ram_Address    (Ram_Address),
        .Ram_Write_Data (Ram_Write_Data),
        .Ram_Mem_Write  (Ram_Mem_Write),
        .Ram_Read_Data  (Ram_Read_Data)
`ifdef MAU_PERF_CNT_EN
        ,
        .Load_Count     (Load_Count),
        .Store_Count    (Store_Count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM model: registered read, write-enable from the DUT, preload port
    logic [31:0] mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge Clock) begin
        if (Ram_Mem_Write) mem[Ram_Address] <= Ram_Write_Data;
        else if (pre_en)   mem[pre_addr]    <= pre_data;
        Ram_Read_Data <= mem[Ram_Address];
    end

    int checks   = 0;
    int failures = 0;

    // Results of the most recent do_req
    int          lat;
    int          n_wr;
    int          w_cyc;
    logic [15:0] w_addr;
    logic [31:0] w_data;
    logic [31:0] rd;
    logic        er;
    logic        rdy_at_req;
    logic        saw_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge
    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge Clock); #1 pre_en = 1'b0;
        @(negedge Clock);
    endtask

    // Issues one request at a falling edge and observes up to 8 cycles
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [17:0] ad, input logic [31:0] wd);
        lat = -1; n_wr = 0; w_cyc = -1; w_addr = '0; w_data = '0; rd = '0; er = 1'b0;
        rdy_at_req = Req_Ready;
        Req_Valid = 1'b1; Req_Write = wr; Req_Size = sz; Req_Signed = sg;
        Req_Addr = ad; Req_Wdata = wd;
        @(posedge Clock); #1 Req_Valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (Ram_Mem_Write) begin
                n_wr++; w_cyc = c; w_addr = Ram_Address; w_data = Ram_Write_Data;
            end
            if (Resp_Valid) begin
                lat = c; rd = Resp_Rdata; er = Resp_Error;
                break;
            end
        end
    endtask

    initial begin
        Reset = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'b00;
        Req_Signed = 1'b0; Req_Addr = '0; Req_Wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // Reset state
        check("rst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
        check("rst_resp_error", {31'd0, Resp_Error}, 32'd0);
        check("rst_resp_rdata", Resp_Rdata, 32'd0);
        check("rst_req_ready", {31'd0, Req_Ready}, 32'd1);
        check("rst_mem_write", {31'd0, Ram_Mem_Write}, 32'd0);

        // Word store then word load at byte 0x10 (word 4)
        do_req(1'b1, 2'b10, 1'b0, 18'h00010, 32'h12345678);
        check("wst_ready", {31'd0, rdy_at_req}, 32'd1);
        check("wst_latency", lat, 32'd2);
        check("wst_nwrites", n_wr, 32'd1);
        check("wst_write_cycle", w_cyc, 32'd1);
        check("wst_write_addr", {16'd0, w_addr}, 32'h4);
        check("wst_write_data", w_data, 32'h12345678);
        check("wst_error", {31'd0, er}, 32'd0);
        check("wst_mem", mem[4], 32'h12345678);
        do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0);
        check("wld_latency", lat, 32'd3);
        check("wld_rdata", rd, 32'h12345678);
        check("wld_error", {31'd0, er}, 32'd0);
        check("wld_nwrites", n_wr, 32'd0);
        @(negedge Clock);
        check("wld_pulse_one_cycle", {31'd0, Resp_Valid}, 32'd0);
        check("wld_rdata_hold", Resp_Rdata, 32'h12345678);

        // Sub-word stores: read-modify-write
        preload(16'd4, 32'hAABBCCDD);
        do_req(1'b1, 2'b00, 1'b0, 18'h00012, 32'h00000011);
        check("bst_latency", lat, 32'd4);
        check("bst_nwrites", n_wr, 32'd1);
        check("bst_write_cycle", w_cyc, 32'd3);
        check("bst_write_data", w_data, 32'hAA11CCDD);
        check("bst_mem", mem[4], 32'hAA11CCDD);
        check("bst_rdata", rd, 32'h0);
        preload(16'd5, 32'h55667788);
        do_req(1'b1, 2'b01, 1'b0, 18'h00016, 32'hDEAD1234);
        check("hst_latency", lat, 32'd4);
        check("hst_mem", mem[5], 32'h12347788);

        // Sub-word loads with extension, word 8 = byte 0x20
        preload(16'd8, 32'h80FF7F01);
        do_req(1'b0, 2'b00, 1'b1, 18'h00021, 32'h0);
        check("ld_sb_p1", rd, 32'h0000007F);
        check("ld_sb_p1_latency", lat, 32'd3);
        do_req(1'b0, 2'b00, 1'b1, 18'h00022, 32'h0);
        check("ld_sb_p2", rd, 32'hFFFFFFFF);
        do_req(1'b0, 2'b00, 1'b0, 18'h00023, 32'h0);
        check("ld_ub_p3", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 18'h00022, 32'h0);
        check("ld_uh_p2", rd, 32'h000080FF);
        do_req(1'b0, 2'b01, 1'b1, 18'h00022, 32'h0);
        check("ld_sh_p2", rd, 32'hFFFF80FF);
        do_req(1'b0, 2'b01, 1'b1, 18'h00020, 32'h0);
        check("ld_sh_p0", rd, 32'h00007F01);

        // Error paths
        preload(16'd1, 32'hCAFEF00D);
        do_req(1'b0, 2'b01, 1'b0, 18'h00003, 32'h0);
        check("err_half_latency", lat, 32'd1);
        check("err_half_error", {31'd0, er}, 32'd1);
        check("err_half_rdata", rd, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 18'h00006, 32'h99999999);
        check("err_word_latency", lat, 32'd1);
        check("err_word_error", {31'd0, er}, 32'd1);
        check("err_word_nwrites", n_wr, 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 18'h00010, 32'h77777777);
        check("err_size_latency", lat, 32'd1);
        check("err_size_error", {31'd0, er}, 32'd1);
        check("err_size_nwrites", n_wr, 32'd0);
        repeat (4) @(negedge Clock);
        check("err_mem1_unchanged", mem[1], 32'hCAFEF00D);
        check("err_mem4_unchanged", mem[4], 32'hAA11CCDD);

        // Back-to-back loads with Req_Valid held high
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'b10; Req_Signed = 1'b0;
        Req_Addr = 18'h00020;
        @(posedge Clock); #1 Req_Addr = 18'h00010;
        @(negedge Clock);
        check("b2b_c1_ready", {31'd0, Req_Ready}, 32'd0);
        @(negedge Clock);
        check("b2b_c2_ready", {31'd0, Req_Ready}, 32'd0);
        check("b2b_c2_valid", {31'd0, Resp_Valid}, 32'd0);
        @(negedge Clock);
        check("b2b_c3_valid", {31'd0, Resp_Valid}, 32'd1);
        check("b2b_c3_rdata", Resp_Rdata, 32'h80FF7F01);
        check("b2b_c3_ready", {31'd0, Req_Ready}, 32'd1);
        @(posedge Clock); #1 Req_Valid = 1'b0;
        @(negedge Clock);
        check("b2b_c4_valid", {31'd0, Resp_Valid}, 32'd0);
        check("b2b_c4_ready", {31'd0, Req_Ready}, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        check("b2b_c6_valid", {31'd0, Resp_Valid}, 32'd1);
        check("b2b_c6_rdata", Resp_Rdata, 32'hAA11CCDD);
        @(negedge Clock);

        // Reset asserted during MERGE
        preload(16'd6, 32'h01020304);
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b00; Req_Addr = 18'h00018;
        Req_Wdata = 32'h00000099;
        @(posedge Clock); #1 Req_Valid = 1'b0;
        repeat (3) @(negedge Clock);
        check("mrg_write_active", {31'd0, Ram_Mem_Write}, 32'd1);
        #1 Reset = 1'b0;
        #1;
        check("mrg_rst_write", {31'd0, Ram_Mem_Write}, 32'd0);
        check("mrg_rst_ready", {31'd0, Req_Ready}, 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            if (Resp_Valid) saw_resp = 1'b1;
        end
        check("mrg_no_resp", {31'd0, saw_resp}, 32'd0);
        check("mrg_ready_after", {31'd0, Req_Ready}, 32'd1);

`ifdef MAU_PERF_CNT_EN
        check("perf_rst_load", Load_Count, 32'd0);
        check("perf_rst_store", Store_Count, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 18'h00020, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 18'h00021, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 18'h00022, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 18'h00030, 32'h1);
        do_req(1'b1, 2'b00, 1'b0, 18'h00031, 32'h2);
        do_req(1'b0, 2'b10, 1'b0, 18'h00031, 32'h0);
        @(negedge Clock);
        check("perf_load", Load_Count, 32'd3);
        check("perf_store", Store_Count, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
